// File: rtl/btn_event_queue.sv
// btn_event_queue: synchronises and debounces N_BTN raw buttons, turns each
// debounced press into a one-word event and queues the events in a
// first-word-fall-through FIFO that the CPU pops one at a time.
// Optional build macro BTN_RELEASE_EN: debounced releases also queue an event,
// with bit ID_W of the event word set.
module btn_event_queue #(
  parameter int N_BTN     = 5,
  parameter int DB_CYCLES = 16,
  parameter int DEPTH     = 8,
  parameter int DATA_W    = 26
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_BTN-1:0]       btn,
  input  logic                   pop,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   clr_ovf
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam int ID_W  = (N_BTN > 1) ? $clog2(N_BTN) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;
`ifdef BTN_RELEASE_EN
  localparam int EV_W  = ID_W + 1;
`else
  localparam int EV_W  = ID_W;
`endif

  logic [N_BTN-1:0] sync1, sync2, stable;
  logic [CNT_W-1:0] cnt [N_BTN];
  logic [N_BTN-1:0] accept;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] pend_press;
  logic [N_BTN-1:0] clr_press;
`ifdef BTN_RELEASE_EN
  logic [N_BTN-1:0] fall;
  logic [N_BTN-1:0] pend_rel;
  logic [N_BTN-1:0] clr_rel;
`endif

  logic             push;
  logic [EV_W-1:0]  push_ev;
  logic [EV_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic             full;
  logic             pop_ok;
  logic             push_ok;
  logic             drop;

  // Two-flop synchroniser for the asynchronous button levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // A button's synchronised level is accepted on its DB_CYCLES-th consecutive disagreeing cycle.
  always_comb begin
    accept = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_W'(DB_CYCLES - 1));
    end
  end

  assign rise = accept & sync2;
`ifdef BTN_RELEASE_EN
  assign fall = accept & ~sync2;
`endif

  // Debounce counters and accepted stable levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Pick one pending request per cycle: presses first, then releases, lowest index first.
  always_comb begin
    push      = 1'b0;
    push_ev   = '0;
    clr_press = '0;
`ifdef BTN_RELEASE_EN
    clr_rel   = '0;
`endif
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (!push && pend_press[i]) begin
        push                = 1'b1;
        push_ev[ID_W-1:0]   = ID_W'(i);
        clr_press[i]        = 1'b1;
      end
    end
`ifdef BTN_RELEASE_EN
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (!push && pend_rel[i]) begin
        push                = 1'b1;
        push_ev[ID_W-1:0]   = ID_W'(i);
        push_ev[ID_W]       = 1'b1;
        clr_rel[i]          = 1'b1;
      end
    end
`endif
  end

  // Pending masks: the served bit clears, a new edge sets (a repeat edge merges).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_press <= '0;
`ifdef BTN_RELEASE_EN
      pend_rel   <= '0;
`endif
    end else begin
      pend_press <= (pend_press & ~clr_press) | rise;
`ifdef BTN_RELEASE_EN
      pend_rel   <= (pend_rel & ~clr_rel) | fall;
`endif
    end
  end

  assign count   = wptr - rptr;
  assign valid   = (count != '0);
  assign full    = (count == PTR_W'(DEPTH));
  assign pop_ok  = pop & valid;
  // When full, a simultaneous pop frees the slot the push lands in.
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & full & ~pop_ok;

  // FIFO storage and pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wptr[AW-1:0]] <= push_ev;
        wptr              <= wptr + PTR_W'(1);
      end
      if (pop_ok) begin
        rptr <= rptr + PTR_W'(1);
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  // Head word, zero-extended, forced to 0 when empty.
  always_comb begin
    rd_data = '0;
    if (valid) begin
      rd_data = DATA_W'(mem[rptr[AW-1:0]]);
    end
  end

endmodule

// File: tb/tb_btn_event_queue.sv
// Self-checking bench for btn_event_queue: an event-level reference model
// (debounce as a run length of disagreeing samples, pending flags, a queue of
// event words) checked against the DUT every cycle, plus directed scenarios
// with literal expectations. Honours BTN_RELEASE_EN like the design.
module tb_btn_event_queue;

  localparam int N_BTN     = 5;
  localparam int DB_CYCLES = 16;
  localparam int DEPTH     = 8;
  localparam int DATA_W    = 26;
  localparam int ID_W      = 3;

  logic                   clk;
  logic                   rst_n;
  logic [N_BTN-1:0]       btn;
  logic                   pop;
  logic [DATA_W-1:0]      rd_data;
  logic                   valid;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic                   clr_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  bit sh1 [N_BTN];
  bit sh2 [N_BTN];
  bit stab[N_BTN];
  int run [N_BTN];
  bit pp  [N_BTN];
  bit pr  [N_BTN];
  int q[$];
  bit m_ovf;

  btn_event_queue #(
    .N_BTN(N_BTN), .DB_CYCLES(DB_CYCLES), .DEPTH(DEPTH), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .pop(pop), .rd_data(rd_data),
    .valid(valid), .count(count), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_BTN; i++) begin
      sh1[i] = 0; sh2[i] = 0; stab[i] = 0; run[i] = 0; pp[i] = 0; pr[i] = 0;
    end
    q.delete();
    m_ovf = 0;
  endtask

  function automatic bit any_pending();
    bit r = 0;
    for (int i = 0; i < N_BTN; i++) r = r | pp[i] | pr[i];
    return r;
  endfunction

  // One clock of the event-level model, from pre-edge state and inputs.
  task automatic model_step();
    int  pid = -1;
    bit  rel = 0;
    bit  drop = 0;
    bit  pop_ok;
    bit  was_full;
    for (int i = 0; i < N_BTN; i++) if (pid < 0 && pp[i]) pid = i;
`ifdef BTN_RELEASE_EN
    for (int i = 0; i < N_BTN; i++) if (pid < 0 && pr[i]) begin pid = i; rel = 1; end
`endif
    was_full = (q.size() == DEPTH);
    pop_ok   = pop && (q.size() > 0);
    if (pop_ok) q.delete(0);
    if (pid >= 0) begin
      if (rel) pr[pid] = 0; else pp[pid] = 0;
      if (was_full && !pop_ok) drop = 1;
      else q.push_back(rel ? pid + (1 << ID_W) : pid);
    end
    if (drop) m_ovf = 1;
    else if (clr_ovf) m_ovf = 0;
    for (int i = 0; i < N_BTN; i++) begin
      if (sh2[i] != stab[i]) begin
        run[i]++;
        if (run[i] == DB_CYCLES) begin
          stab[i] = sh2[i];
          run[i]  = 0;
          if (stab[i]) pp[i] = 1;
`ifdef BTN_RELEASE_EN
          else pr[i] = 1;
`endif
        end
      end else begin
        run[i] = 0;
      end
    end
    for (int i = 0; i < N_BTN; i++) begin
      sh2[i] = sh1[i];
      sh1[i] = btn[i];
    end
  endtask

  // Model process: follows the clock and the asynchronous reset.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Compare process: every cycle, DUT outputs against the model.
  initial begin
    repeat (2) @(posedge clk);
    forever begin
      @(negedge clk);
      check("rd_data",  rd_data,  (q.size() > 0) ? q[0] : 0);
      check("valid",    valid,    q.size() > 0);
      check("count",    count,    q.size());
      check("overflow", overflow, m_ovf);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drain();
    btn = '0;
    pop = 1'b1;
    tick(45);
    pop = 1'b0;
  endtask

  task automatic press_release(input int id);
    btn[id] = 1'b1;
    tick(22);
    btn[id] = 1'b0;
    tick(22);
  endtask

  int exp_seq[8];
  int hold_left[N_BTN];
  bit level[N_BTN];
  int pop_pct;

  initial begin
    rst_n = 1'b0; btn = '0; pop = 1'b0; clr_ovf = 1'b0;
    tick(3);

    // Reset with button 0 held
    btn = 5'b00001;
    tick(3);
    check("rst_count", count, 0);
    check("rst_valid", valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    tick(20);
    check("held_valid", valid, 1);
    check("held_rd_data", rd_data, 0);
    check("held_count", count, 1);
    drain();

    // Glitch then genuine press on button 2
    btn[2] = 1'b1; tick(10); btn[2] = 1'b0; tick(30);
    check("glitch_count", count, 0);
    btn[2] = 1'b1; tick(20);
    check("press2_count", count, 1);
    check("press2_rd_data", rd_data, 2);
    drain();

    // Simultaneous presses on buttons 4 and 1
    btn = 5'b10010;
    tick(19);
    check("simul_first_count", count, 1);
    check("simul_first_rd", rd_data, 1);
    tick(1);
    check("simul_count", count, 2);
    check("simul_head", rd_data, 1);
    pop = 1'b1; tick(1); pop = 1'b0;
    check("simul_second_rd", rd_data, 4);
    drain();

    // Nine presses with no pop
    for (int k = 0; k < 9; k++) press_release(k % N_BTN);
    check("full_count", count, 8);
    check("full_overflow", overflow, 1);
`ifdef BTN_RELEASE_EN
    exp_seq = '{0, 8, 1, 9, 2, 10, 3, 11};
`else
    exp_seq = '{0, 1, 2, 3, 4, 0, 1, 2};
`endif
    for (int k = 0; k < 8; k++) begin
      check("full_pop_seq", rd_data, exp_seq[k]);
      pop = 1'b1; tick(1); pop = 1'b0;
    end
    check("full_drained", count, 0);
    clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Push and pop together while full
    for (int k = 0; k < 20 && q.size() < DEPTH; k++) press_release(k % N_BTN);
    check("refill_count", count, 8);
    clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
    btn[3] = 1'b1;
    for (int k = 0; k < 40 && !any_pending(); k++) tick(1);
    if (!any_pending()) check("push_wait_timeout", 1, 0);
    pop = 1'b1; tick(1); pop = 1'b0;
    check("pushpop_full_count", count, 8);
    check("pushpop_full_ovf", overflow, 0);
    drain();
    pop = 1'b1; tick(3); pop = 1'b0;
    check("pop_empty_count", count, 0);
    check("pop_empty_rd", rd_data, 0);
    check("pop_empty_valid", valid, 0);

`ifdef BTN_RELEASE_EN
    // Press then release button 3
    press_release(3);
    check("rel_count", count, 2);
    check("rel_press_word", rd_data, 3);
    pop = 1'b1; tick(1); pop = 1'b0;
    check("rel_release_word", rd_data, 11);
    drain();
`endif

    // Randomised button activity, pops, clears and mid-run resets
    for (int i = 0; i < N_BTN; i++) begin
      hold_left[i] = 0;
      level[i] = 0;
    end
    pop_pct = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) pop_pct = $urandom_range(0, 3) * 15;
      for (int i = 0; i < N_BTN; i++) begin
        if (hold_left[i] == 0) begin
          level[i] = 1'($urandom_range(0, 1));
          hold_left[i] = $urandom_range(1, 45);
        end else begin
          hold_left[i]--;
        end
        btn[i] = level[i];
      end
      pop = ($urandom_range(0, 99) < pop_pct);
      clr_ovf = ($urandom_range(0, 99) < 2);
      if (c == 1500 || c == 3200) rst_n = 1'b0;
      if (c == 1503 || c == 3202) rst_n = 1'b1;
      tick(1);
    end
    pop = 1'b0; clr_ovf = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_event_queue.md
Name: btn_event_queue

Overview:
- Parametrised input unit for the puzzle CPU. It is the successor to the direct button wiring into io.
- Synchronises and debounces N_BTN raw buttons and detects press edges.
- Queues one event per press in a FIFO. The CPU pops events one at a time, so no press is missed at divided-clock speed.
- Sits between the board buttons and the regfile/io read path, in the divided clk domain.

Parameters:
- N_BTN, 5: number of buttons (1..16).
- DB_CYCLES, 16: consecutive stable clk cycles required to accept a level change (>=2).
- DEPTH, 8: FIFO depth in events, power of 2 (2..64).
- DATA_W, 26: width of rd_data; matches the CPU register width.

Ports:
- clk, input, 1: system clock (divided clock from divider).
- rst_n, input, 1: asynchronous active-low reset.
- btn, input, N_BTN: raw asynchronous button levels, 1 = pressed.
- pop, input, 1: CPU consumes the head event this cycle.
- rd_data, output, DATA_W: head event word; 0 when empty.
- valid, output, 1: FIFO not empty.
- count, output, clog2(DEPTH)+1: number of queued events.
- overflow, output, 1: sticky flag; an event was dropped because the FIFO was full.
- clr_ovf, input, 1: clears overflow.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n), applied to every flop.
- Reset values: rd_data=0, valid=0, count=0, overflow=0. Sync flops, stable levels, counters, pending mask and pointers all 0.
- Synchroniser: 2-flop synchroniser per button, giving s[i].
- Debounce, per button: counter cnt[i], width clog2(DB_CYCLES).
  - If s[i]==stable[i]: cnt[i]<=0.
  - Otherwise cnt[i] increments.
  - When cnt[i]==DB_CYCLES-1 and s[i]!=stable[i]: stable[i]<=s[i] and cnt[i]<=0.
  - A glitch shorter than DB_CYCLES resets the count and never changes stable.
- Edge detect: a press is stable[i] going 0->1. It sets pending[i] in the same cycle the stable change is registered.
- Press latency: a clean press at btn reaches stable after 2+DB_CYCLES cycles. valid rises 1 cycle after pending is set, given no backlog.
- Enqueue arbitration:
  - Each cycle, if pending!=0, the lowest set index k is pushed and pending[k] is cleared.
  - This gives at most one push per cycle. Simultaneous presses drain lowest-index first on consecutive cycles.
  - A new press on a button whose pending bit is already set merges with it (no second event).
- Event word: bits [ID_W-1:0] hold the button index, with ID_W=clog2(N_BTN), minimum 1. All other bits are 0.
- Read side:
  - First-word-fall-through: rd_data shows the head combinationally from the registered FIFO, and is forced to 0 when empty.
  - pop with valid=1 advances the read pointer.
  - pop with valid=0 is ignored: no pointer change, no error.
- Full handling:
  - A push while count==DEPTH with no pop in that cycle is dropped. The pending bit is still cleared and overflow<=1.
  - Push and pop in the same cycle when full both succeed; count stays DEPTH and overflow is not set.
  - Push and pop in the same cycle when empty: the push is stored and the pop is ignored, so count becomes 1.
- Pointers: log2(DEPTH)+1 bits, wrap naturally. count = wptr - rptr.
- Overflow flag: clr_ovf clears overflow. If clr_ovf coincides with a new drop, set wins.
- Reset mid-operation: asynchronous assertion clears the queue, pending mask and debounce state immediately. A button held through reset release is seen as a press after 2+DB_CYCLES cycles.

Optional Feature:
- Macro: BTN_RELEASE_EN.
- When defined:
  - A stable 1->0 transition also raises a pending release request, kept in a separate mask.
  - Arbitration scans presses first, then releases, lowest index first.
  - A release event word has bit ID_W set to 1, plus the button index; press words have bit ID_W=0.
- When undefined: releases generate nothing and the release logic is absent.

Test Plan:
- Reset: assert rst_n=0 with btn=5'b00001 held -> outputs all 0. After release, valid=1 with rd_data=0 within 2+16+2 cycles.
- Debounce: glitch btn[2] high for 10 cycles -> no event. Hold high 20 cycles -> exactly one event, rd_data=2.
- Simultaneous presses: btn[4] and btn[1] rise in the same cycle -> events queued as 1 then 4 on consecutive cycles, count reaches 2.
- Full FIFO, DEPTH=8: generate 9 presses with no pop -> count=8, overflow=1, and rd_data sequence on popping matches the first 8 presses. clr_ovf -> overflow=0.
- Full boundary: count=8 with push and pop in the same cycle -> count stays 8, overflow stays 0. pop while empty -> count 0, rd_data 0.
- With BTN_RELEASE_EN: press then release btn[3] -> rd_data 3 followed by 3|(1<<3)=11.
